// File: rtl/chase_pkg.sv
// chase_pkg: shared definitions for the LED chase monitor.
//   chase_state_t : monitor state (IDLE, TRACK, LOCKED, FAULT)
//   STEP_CNT_W    : width of the good-step counter
package chase_pkg;

    localparam int unsigned STEP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } chase_state_t;

endpackage

// File: rtl/chase_monitor_if.sv
// chase_monitor_if: observed LED bus, clear control and monitor status.
//   clear       : synchronous clear request
//   led_in      : LED bus under observation
//   locked      : monitor is locked onto the rotation
//   err_onehot  : sticky, bus was not one-hot while tracking
//   err_step    : sticky, a change was not a 1-position left rotation
//   err_period  : sticky, a change came too soon after the previous one
//   position    : index of the lit LED
//   step_count  : number of good steps (wraps)
//   last_period : measured gap of the most recent good step
// master drives the bus and clear; slave is the monitor.
interface chase_monitor_if
    import chase_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PERIOD_W = 16
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic                  clear;
    logic [WIDTH-1:0]      led_in;
    logic                  locked;
    logic                  err_onehot;
    logic                  err_step;
    logic                  err_period;
    logic [IDX_W-1:0]      position;
    logic [STEP_CNT_W-1:0] step_count;
    logic [PERIOD_W-1:0]   last_period;

    modport master (
        output clear, led_in,
        input  locked, err_onehot, err_step, err_period,
        input  position, step_count, last_period
    );

    modport slave (
        input  clear, led_in,
        output locked, err_onehot, err_step, err_period,
        output position, step_count, last_period
    );

endinterface

// File: rtl/chase_onehot_decode.sv
// chase_onehot_decode: combinational one-hot check and bit-index decode.
//   bus       : WIDTH-bit input vector
//   is_onehot : exactly one bit of bus is set
//   index     : position of the set bit (meaningful only when is_onehot)
module chase_onehot_decode #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] bus,
    output logic             is_onehot,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        is_onehot = $onehot(bus);
        index     = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bus[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/chase_monitor.sv
// chase_monitor: receive-side checker for the one-hot rotating LED bus.
// Samples the bus every clock, checks for single-step left rotations no
// faster than TICKS_PER_STEP cycles apart, and reports lock status, sticky
// error flags, step count and measured step period.
//   clk   : clock (same domain as the chaser)
//   rst_n : asynchronous active-low reset
//   bus   : chase_monitor_if slave (clear, led_in in; status out)
module chase_monitor
    import chase_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned TICKS_PER_STEP = 4,
    parameter int unsigned LOCK_STEPS     = 2,
    parameter int unsigned PERIOD_W       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    chase_monitor_if.slave bus
);

    localparam int unsigned IDX_W  = $clog2(WIDTH);
    localparam int unsigned GOOD_W = $clog2(LOCK_STEPS + 1);

    localparam logic [GOOD_W-1:0]   LOCK_TARGET = GOOD_W'(LOCK_STEPS);
    localparam logic [PERIOD_W-1:0] MIN_GAP     = PERIOD_W'(TICKS_PER_STEP);

    logic [WIDTH-1:0]      led_q;
    logic [WIDTH-1:0]      led_prev;
    logic [PERIOD_W-1:0]   gap_cnt;
    logic [PERIOD_W-1:0]   gap_cnt_nxt;
    logic [PERIOD_W-1:0]   gap_meas;
    chase_state_t          state;
    chase_state_t          state_nxt;
    logic [GOOD_W-1:0]     good_cnt;
    logic [GOOD_W-1:0]     good_cnt_nxt;
    logic [GOOD_W-1:0]     good_inc;
    logic                  first_pending;
    logic                  first_pending_nxt;
    logic                  err_onehot_q;
    logic                  err_onehot_nxt;
    logic                  err_step_q;
    logic                  err_step_nxt;
    logic                  err_period_q;
    logic                  err_period_nxt;
    logic [IDX_W-1:0]      position_q;
    logic [IDX_W-1:0]      position_nxt;
    logic [STEP_CNT_W-1:0] step_count_q;
    logic [STEP_CNT_W-1:0] step_count_nxt;
    logic [PERIOD_W-1:0]   last_period_q;
    logic [PERIOD_W-1:0]   last_period_nxt;

    logic                  dec_onehot;
    logic [IDX_W-1:0]      dec_index;
    logic                  change;
    logic                  rotation;
    logic                  v_onehot;
    logic                  v_step;
    logic                  v_period;
    logic                  violation;

    chase_onehot_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .bus       (led_q),
        .is_onehot (dec_onehot),
        .index     (dec_index)
    );

    always_comb begin
        change   = (led_q != led_prev);
        rotation = (led_q == {led_prev[WIDTH-2:0], led_prev[WIDTH-1]});
        // Saturating gap+1: the cycle count since the previous change,
        // and also the free-running increment of the gap counter.
        gap_meas    = (&gap_cnt) ? gap_cnt : gap_cnt + 1'b1;
        gap_cnt_nxt = change ? '0 : gap_meas;
        v_onehot    = !dec_onehot;
        v_step      = change && !rotation;
        v_period    = change && !first_pending && (gap_meas < MIN_GAP);
        violation   = v_onehot || v_step || v_period;
        good_inc    = good_cnt + 1'b1;
    end

    always_comb begin
        state_nxt         = state;
        good_cnt_nxt      = good_cnt;
        first_pending_nxt = first_pending;
        err_onehot_nxt    = err_onehot_q;
        err_step_nxt      = err_step_q;
        err_period_nxt    = err_period_q;
        step_count_nxt    = step_count_q;
        last_period_nxt   = last_period_q;
        position_nxt      = dec_onehot ? dec_index : position_q;

        case (state)
            IDLE: begin
                if (dec_onehot) begin
                    state_nxt         = TRACK;
                    good_cnt_nxt      = '0;
                    first_pending_nxt = 1'b1;
                end
            end
            TRACK, LOCKED: begin
                if (violation) begin
                    state_nxt      = FAULT;
                    err_onehot_nxt = err_onehot_q | v_onehot;
                    err_step_nxt   = err_step_q   | v_step;
                    err_period_nxt = err_period_q | v_period;
                end else if (change) begin
                    // No violation plus a change means a good rotation.
                    step_count_nxt = step_count_q + 1'b1;
                    if (state == TRACK) begin
                        good_cnt_nxt = good_inc;
                        if (first_pending) begin
                            first_pending_nxt = 1'b0;
                        end else begin
                            last_period_nxt = gap_meas;
                        end
                        if (good_inc == LOCK_TARGET) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        last_period_nxt = gap_meas;
                    end
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q         <= '0;
            led_prev      <= '0;
            gap_cnt       <= '0;
            state         <= IDLE;
            good_cnt      <= '0;
            first_pending <= 1'b0;
            err_onehot_q  <= 1'b0;
            err_step_q    <= 1'b0;
            err_period_q  <= 1'b0;
            position_q    <= '0;
            step_count_q  <= '0;
            last_period_q <= '0;
        end else begin
            led_q    <= bus.led_in;
            // Also on clear: the reload keeps clear from creating a change.
            led_prev <= led_q;
            if (bus.clear) begin
                gap_cnt       <= '0;
                state         <= IDLE;
                good_cnt      <= '0;
                first_pending <= 1'b0;
                err_onehot_q  <= 1'b0;
                err_step_q    <= 1'b0;
                err_period_q  <= 1'b0;
                position_q    <= '0;
                step_count_q  <= '0;
                last_period_q <= '0;
            end else begin
                gap_cnt       <= gap_cnt_nxt;
                state         <= state_nxt;
                good_cnt      <= good_cnt_nxt;
                first_pending <= first_pending_nxt;
                err_onehot_q  <= err_onehot_nxt;
                err_step_q    <= err_step_nxt;
                err_period_q  <= err_period_nxt;
                position_q    <= position_nxt;
                step_count_q  <= step_count_nxt;
                last_period_q <= last_period_nxt;
            end
        end
    end

    assign bus.locked      = (state == LOCKED);
    assign bus.err_onehot  = err_onehot_q;
    assign bus.err_step    = err_step_q;
    assign bus.err_period  = err_period_q;
    assign bus.position    = position_q;
    assign bus.step_count  = step_count_q;
    assign bus.last_period = last_period_q;

endmodule

// File: doc/chase_monitor.md
# chase_monitor

Receive-side checker for the one-hot rotating LED bus driven by the team's light-chaser. It samples the LED vector every clock and decodes the lit position. It verifies that each change is a single-step left rotation, that steps are never faster than the configured rate, and that the bus stays one-hot. It reports lock status, sticky error flags, step count and measured step period. It sits on the same clock as the chaser, either as a self-check in the LED subsystem or as an on-chip monitor of a looped-back LED bus.

## Interface
- WIDTH, 8: LED bus width; must be ≥2.
- TICKS_PER_STEP, 4: minimum legal cycles between two LED changes; must be ≥1.
- LOCK_STEPS, 2: consecutive good steps required to go from TRACK to LOCKED; must be ≥1.
- PERIOD_W, 16: width of the gap counter and last_period; saturating.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous clear; highest priority after reset.
- led_in  in  WIDTH  LED bus under observation; same clock domain, no synchroniser.
- locked  out  1  high while state is LOCKED.
- err_onehot  out  1  sticky; bus was not one-hot while tracking.
- err_step  out  1  sticky; a change was not a 1-position left rotation.
- err_period  out  1  sticky; a change came fewer than TICKS_PER_STEP cycles after the previous one.
- position  out  $clog2(WIDTH)  index of the lit bit; holds its last value when the bus is not one-hot.
- step_count  out  16  count of good steps; wraps at 2^16.
- last_period  out  PERIOD_W  measured gap of the most recent good step.

## Operation
- Input stage: led_q <= led_in and led_prev <= led_q. A change event is led_q != led_prev.
- A rotation is expected when led_q == {led_prev[WIDTH-2:0], led_prev[WIDTH-1]}. The wrap from bit WIDTH-1 to bit 0 is legal.
- Gap counter:
  - On a change event it loads 0; otherwise it increments, saturating at all-ones.
  - The measured gap at a change event is gap_cnt+1, saturated. This is the number of cycles since the previous change.
- States (the enum lives in the package):
  - IDLE
    - Goes to TRACK when led_q is one-hot; good_cnt <= 0; first_pending <= 1.
    - Non-one-hot values are ignored.
  - TRACK
    - A change event that is a rotation counts as a good step: step_count++ and good_cnt++.
    - The gap is not checked when first_pending = 1. On that step last_period is not updated, and first_pending is cleared.
    - Goes to LOCKED when good_cnt reaches LOCK_STEPS.
  - LOCKED
    - Good steps increment step_count and update last_period.
    - A gap longer than TICKS_PER_STEP is legal; it covers a paused chaser.
  - FAULT
    - Entered from TRACK or LOCKED on any violation. Sticky until clear or reset.
    - No counters advance; position still tracks.
- Violations in TRACK/LOCKED, evaluated each cycle; all that apply are flagged in the same cycle:
  - led_q not one-hot sets err_onehot.
  - A change event that is not a rotation sets err_step.
  - A change event with measured gap < TICKS_PER_STEP and first_pending = 0 sets err_period.
- clear:
  - Returns the block to IDLE.
  - Zeroes the error flags, step_count, last_period, gap_cnt, good_cnt and position.
  - Reloads led_prev from led_q, so clear itself never produces a change event.

## Timing
- Reset values:
  - All outputs 0.
  - Internal registers 0; state IDLE.
- Latency:
  - If led_in takes a new value before edge k, led_q updates at edge k.
  - State, flags, step_count, last_period and position update at edge k+1, i.e. 2 cycles after the input changes.
- In the cycle that reaches LOCK_STEPS, locked rises together with the step_count update.
- Error flags rise on the same edge that enters FAULT; locked falls on that same edge.
- Reset mid-operation aborts immediately, asynchronously, to the reset values.
- clear asserted on edge k: outputs show the cleared values after edge k. led_in on that edge is captured into led_q as normal.

## Structure
- Package chase_pkg holds:
  - the state enum typedef (IDLE, TRACK, LOCKED, FAULT);
  - the localparam STEP_CNT_W = 16.
- Sub-module chase_onehot_decode:
  - Purely combinational on a WIDTH bus.
  - Outputs is_onehot and index.
  - Instantiated once on led_q.
- The top level holds the input/previous registers, gap counter, state machine, sticky flags and output registers. Target is roughly 150–250 lines.

## Test plan
All scenarios use WIDTH=8, TICKS_PER_STEP=4, LOCK_STEPS=2.
- Lock-up: reset, then led_in=8'h01, then 8'h02 and 8'h04 each held 4 cycles. Required: locked=1 two cycles after 8'h04 is applied, step_count=2, all errors 0.
- Pause and wrap: in LOCKED, hold 8'h80 for 20 cycles, then drive 8'h01. Required: no error, position 7→0, last_period=20, step_count incremented by 1.
- Early step: in LOCKED, change 8'h04→8'h08 after 2 cycles. Required: err_period=1, locked=0, state FAULT, step_count unchanged.
- Bad rotation and one-hot:
  - Drive 8'h02→8'h08 after 4 cycles. Required: err_step only.
  - Separately, from a fresh lock drive 8'h03. Required: err_onehot=1, position holds its previous value.
- Clear and idle filtering: in FAULT, pulse clear with led_in=8'h00. Required: all outputs 0, state IDLE. Then 8'h00 held 10 cycles keeps IDLE with no errors.
- Reset mid-lock: assert rst_n=0 asynchronously between edges while LOCKED with step_count=5. Required: all outputs 0 immediately. After release, lock-up repeats as in the first scenario.
